// File: rtl/session_pkg.sv
// Shared types and constants for the session sequencer.
// SESSION_PAUSE_EN adds the PAUSE state to the encoding.
package session_pkg;
  localparam int TIME_W = 8;
  localparam int MODE_W = 2;

  localparam int T0_DEF = 10;
  localparam int T1_DEF = 30;
  localparam int T2_DEF = 60;
  localparam int T3_DEF = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
`ifdef SESSION_PAUSE_EN
    ST_PAUSE,
`endif
    ST_DONE
  } state_t;
endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector on a debounced level; pulse is combinational off the previous-value flop.
// RST_VAL=1 keeps a level held through reset from firing once reset releases.
module rise_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= RST_VAL;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;
endmodule

// File: rtl/session_ctrl.sv
// Session sequencer: IDLE -> ARM -> RUN -> DONE countdown, all outputs registered, no backpressure.
// Optional pause on a start edge in RUN is enabled by SESSION_PAUSE_EN.
module session_ctrl
  import session_pkg::*;
#(
  parameter int T0 = T0_DEF,
  parameter int T1 = T1_DEF,
  parameter int T2 = T2_DEF,
  parameter int T3 = T3_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              tick,
  input  logic [MODE_W-1:0] mode,
  output logic              idle,
  output logic              start,
  output logic              running,
  output logic [MODE_W-1:0] active_mode,
  output logic [TIME_W-1:0] time_left,
  output logic              done
);
  if (T0 < 1 || T0 > 255 || T1 < 1 || T1 > 255 ||
      T2 < 1 || T2 > 255 || T3 < 1 || T3 > 255) begin : g_bad_duration
    $error("session_ctrl: durations must lie in 1..255");
  end

  function automatic logic [TIME_W-1:0] duration(input logic [MODE_W-1:0] m);
    case (m)
      2'd0:    return TIME_W'(T0);
      2'd1:    return TIME_W'(T1);
      2'd2:    return TIME_W'(T2);
      default: return TIME_W'(T3);
    endcase
  endfunction

  logic start_rise, stop_rise;

  rise_edge #(.RST_VAL(1'b1)) u_start_edge (.clk(clk), .rst(rst), .d(btn_start), .rise(start_rise));
  rise_edge #(.RST_VAL(1'b1)) u_stop_edge  (.clk(clk), .rst(rst), .d(btn_stop),  .rise(stop_rise));

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   time_left_q, time_left_d;
  logic [MODE_W-1:0]   active_mode_q, active_mode_d;
  logic                idle_q, idle_d, start_q, start_d;
  logic                running_q, running_d, done_q, done_d;

  always_comb begin
    state_d       = state_q;
    time_left_d   = time_left_q;
    active_mode_d = active_mode_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: if (start_rise) state_d = ST_ARM;
      ST_ARM: begin
        active_mode_d = mode;
        time_left_d   = duration(mode);
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        // Stop outranks both a pause request and a tick in the same cycle.
        if (stop_rise) begin
          state_d     = ST_IDLE;
          time_left_d = '0;
        end
`ifdef SESSION_PAUSE_EN
        else if (start_rise) state_d = ST_PAUSE;
`endif
        else if (tick && time_left_q != '0) begin
          if (time_left_q == TIME_W'(1)) begin
            time_left_d = '0;
            state_d     = ST_DONE;
            done_d      = 1'b1;
          end else begin
            time_left_d = time_left_q - TIME_W'(1);
          end
        end
      end
`ifdef SESSION_PAUSE_EN
      ST_PAUSE: begin
        if (stop_rise) begin
          state_d     = ST_IDLE;
          time_left_d = '0;
        end else if (start_rise) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_DONE: begin
        time_left_d = '0;
        if (start_rise || stop_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    idle_d    = (state_d == ST_IDLE);
    start_d   = (state_d == ST_ARM);
`ifdef SESSION_PAUSE_EN
    running_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
`else
    running_d = (state_d == ST_RUN);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      time_left_q   <= '0;
      active_mode_q <= '0;
      idle_q        <= 1'b1;
      start_q       <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      time_left_q   <= time_left_d;
      active_mode_q <= active_mode_d;
      idle_q        <= idle_d;
      start_q       <= start_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign idle        = idle_q;
  assign start       = start_q;
  assign running     = running_q;
  assign active_mode = active_mode_q;
  assign time_left   = time_left_q;
  assign done        = done_q;
endmodule
